// File: rtl/calc_req_assembler_pkg.sv
// ----------------------------------------------------------------------------
// calc_req_assembler_pkg
// Shared definitions for the per-port request assembler of the four-port
// calculator: request field widths, command encodings, the error cause and
// assembler state enums, and the packed operation record stored in the FIFO.
// ----------------------------------------------------------------------------
package calc_req_assembler_pkg;

    localparam int REQ_CMD_WIDTH  = 4;
    localparam int REQ_DATA_WIDTH = 32;
    localparam int REQ_TAG_WIDTH  = 2;

    localparam logic [REQ_CMD_WIDTH-1:0] CMD_NOP = 4'd0;
    localparam logic [REQ_CMD_WIDTH-1:0] CMD_ADD = 4'd1;
    localparam logic [REQ_CMD_WIDTH-1:0] CMD_SUB = 4'd2;
    localparam logic [REQ_CMD_WIDTH-1:0] CMD_SHL = 4'd5;
    localparam logic [REQ_CMD_WIDTH-1:0] CMD_SHR = 4'd6;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_CMD  = 2'b01,
        ERR_TAG  = 2'b10,
        ERR_FULL = 2'b11
    } err_cause_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OPND2 = 1'b1
    } asm_state_t;

    typedef struct packed {
        logic [REQ_CMD_WIDTH-1:0]  cmd;
        logic [REQ_DATA_WIDTH-1:0] data1;
        logic [REQ_DATA_WIDTH-1:0] data2;
        logic [REQ_TAG_WIDTH-1:0]  tag;
    } calc_op_t;

    // Only the four arithmetic commands the core implements are legal.
    function automatic logic isLegalCmd(input logic [REQ_CMD_WIDTH-1:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB) ||
               (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

endpackage

// File: rtl/calc_req_assembler_fifo.sv
// ----------------------------------------------------------------------------
// calc_req_fifo
// Synchronous FIFO of calc_op_t records sitting between the request
// assembler and the arithmetic core.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push/pushData write one record (ignored when full unless popping too)
//   pop           remove the head (ignored when empty)
//   popData       head record, all zeros while empty
//   full, empty   occupancy flags
//   count         number of occupied entries
// ----------------------------------------------------------------------------
module calc_req_fifo
    import calc_req_assembler_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  calc_op_t               pushData,
    input  logic                   pop,
    output calc_op_t               popData,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    calc_op_t         mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W:0]   countReg;
    logic             doPush;
    logic             doPop;

    // A push into a full FIFO is still legal when the head leaves in the
    // same cycle, because the write slot equals the slot being vacated.
    always_comb begin
        doPop  = pop && !empty;
        doPush = push && (!full || doPop);
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally since the
    // depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            countReg <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    assign empty   = (countReg == '0);
    assign full    = (countReg == FULL_COUNT);
    assign count   = countReg;
    assign popData = empty ? '0 : mem[rdPtr];

endmodule

// File: rtl/calc_req_assembler.sv
// ----------------------------------------------------------------------------
// calc_req_assembler
// Per-port request front end: assembles the two-cycle request protocol into
// one operation, validates command / tag / FIFO space, buffers accepted
// operations and presents them to the core over valid/ready.
// Ports:
//   ifClk, ifRst                 clock, synchronous active-high reset
//   req_cmd_in/data_in/tag_in    request bus (cmd != 0 starts a request)
//   op_valid, op_ready           core handshake for the FIFO head
//   op_cmd/data1/data2/tag       FIFO head fields
//   tag_release, tag_release_id  frees an in-flight tag
//   err_valid/err_tag/err_cause  one-cycle rejection report
//   busy_tags                    in-flight tag bitmap
//   fifo_count                   FIFO occupancy
// ----------------------------------------------------------------------------
module calc_req_assembler
    import calc_req_assembler_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CMD_W      = REQ_CMD_WIDTH,
    parameter int DATA_W     = REQ_DATA_WIDTH,
    parameter int TAG_W      = REQ_TAG_WIDTH
) (
    input  logic                        ifClk,
    input  logic                        ifRst,
    input  logic [CMD_W-1:0]            req_cmd_in,
    input  logic [DATA_W-1:0]           req_data_in,
    input  logic [TAG_W-1:0]            req_tag_in,
    output logic                        op_valid,
    input  logic                        op_ready,
    output logic [CMD_W-1:0]            op_cmd,
    output logic [DATA_W-1:0]           op_data1,
    output logic [DATA_W-1:0]           op_data2,
    output logic [TAG_W-1:0]            op_tag,
    input  logic                        tag_release,
    input  logic [TAG_W-1:0]            tag_release_id,
    output logic                        err_valid,
    output logic [TAG_W-1:0]            err_tag,
    output logic [1:0]                  err_cause,
    output logic [(2**TAG_W)-1:0]       busy_tags,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int NUM_TAGS = 2 ** TAG_W;

    asm_state_t          state;
    logic [CMD_W-1:0]    cmdReg;
    logic [DATA_W-1:0]   data1Reg;
    logic [TAG_W-1:0]    tagReg;
    logic [NUM_TAGS-1:0] busyReg;
    logic [NUM_TAGS-1:0] releaseMask;
    logic [NUM_TAGS-1:0] setMask;
    logic [NUM_TAGS-1:0] busyAfterRelease;
    logic                errValidReg;
    logic [TAG_W-1:0]    errTagReg;
    err_cause_t          errCauseReg;
    err_cause_t          rejectCause;
    logic                completing;
    logic                popNow;
    logic                fullAfterPop;
    logic                accept;
    logic                fifoFull;
    logic                fifoEmpty;
    calc_op_t            pushOp;
    calc_op_t            headOp;

    // Validation of the request completing this cycle. Releases and pops in
    // the same cycle are applied first so a freed tag or slot is reusable at once.
    always_comb begin
        completing  = (state == OPND2);
        popNow      = !fifoEmpty && op_ready;
        fullAfterPop = fifoFull && !popNow;

        releaseMask = '0;
        if (tag_release) releaseMask[tag_release_id] = 1'b1;
        busyAfterRelease = busyReg & ~releaseMask;

        rejectCause = ERR_NONE;
        if (!isLegalCmd(cmdReg))          rejectCause = ERR_CMD;
        else if (busyAfterRelease[tagReg]) rejectCause = ERR_TAG;
        else if (fullAfterPop)             rejectCause = ERR_FULL;

        accept = completing && (rejectCause == ERR_NONE);

        setMask = '0;
        if (accept) setMask[tagReg] = 1'b1;

        pushOp       = '0;
        pushOp.cmd   = cmdReg;
        pushOp.data1 = data1Reg;
        pushOp.data2 = req_data_in;
        pushOp.tag   = tagReg;
    end

    // Request assembly FSM with the registered error report. Operand 2 is
    // pushed straight from the bus on the completing edge.
    always_ff @(posedge ifClk) begin
        if (ifRst) begin
            state       <= IDLE;
            cmdReg      <= '0;
            data1Reg    <= '0;
            tagReg      <= '0;
            errValidReg <= 1'b0;
            errTagReg   <= '0;
            errCauseReg <= ERR_NONE;
        end else begin
            errValidReg <= 1'b0;
            errTagReg   <= '0;
            errCauseReg <= ERR_NONE;
            case (state)
                IDLE: begin
                    if (req_cmd_in != CMD_NOP) begin
                        cmdReg   <= req_cmd_in;
                        data1Reg <= req_data_in;
                        tagReg   <= req_tag_in;
                        state    <= OPND2;
                    end
                end
                OPND2: begin
                    state <= IDLE;
                    if (!accept) begin
                        errValidReg <= 1'b1;
                        errTagReg   <= tagReg;
                        errCauseReg <= rejectCause;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // In-flight tag bitmap: releases clear, accepts set.
    always_ff @(posedge ifClk) begin
        if (ifRst) busyReg <= '0;
        else       busyReg <= busyAfterRelease | setMask;
    end

    calc_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) opFifo (
        .clk     (ifClk),
        .rst     (ifRst),
        .push    (accept),
        .pushData(pushOp),
        .pop     (popNow),
        .popData (headOp),
        .full    (fifoFull),
        .empty   (fifoEmpty),
        .count   (fifo_count)
    );

    assign op_valid  = !fifoEmpty;
    assign op_cmd    = headOp.cmd;
    assign op_data1  = headOp.data1;
    assign op_data2  = headOp.data2;
    assign op_tag    = headOp.tag;
    assign err_valid = errValidReg;
    assign err_tag   = errTagReg;
    assign err_cause = errCauseReg;
    assign busy_tags = busyReg;

endmodule

// File: tb/tb_calc_req_assembler.sv
// ----------------------------------------------------------------------------
// tb_calc_req_assembler
// Directed self-checking bench for calc_req_assembler: reset values, single
// request, illegal command, tag reuse with release, full FIFO with and
// without a same-cycle pop, and reset in the middle of a request.
// ----------------------------------------------------------------------------
module tb_calc_req_assembler;

    logic        ifClk;
    logic        ifRst;
    logic [3:0]  req_cmd_in;
    logic [31:0] req_data_in;
    logic [1:0]  req_tag_in;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_cmd;
    logic [31:0] op_data1;
    logic [31:0] op_data2;
    logic [1:0]  op_tag;
    logic        tag_release;
    logic [1:0]  tag_release_id;
    logic        err_valid;
    logic [1:0]  err_tag;
    logic [1:0]  err_cause;
    logic [3:0]  busy_tags;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    calc_req_assembler #(
        .FIFO_DEPTH(4),
        .CMD_W     (4),
        .DATA_W    (32),
        .TAG_W     (2)
    ) dut (
        .ifClk         (ifClk),
        .ifRst         (ifRst),
        .req_cmd_in    (req_cmd_in),
        .req_data_in   (req_data_in),
        .req_tag_in    (req_tag_in),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_cmd        (op_cmd),
        .op_data1      (op_data1),
        .op_data2      (op_data2),
        .op_tag        (op_tag),
        .tag_release   (tag_release),
        .tag_release_id(tag_release_id),
        .err_valid     (err_valid),
        .err_tag       (err_tag),
        .err_cause     (err_cause),
        .busy_tags     (busy_tags),
        .fifo_count    (fifo_count)
    );

    // 10 ns clock
    initial ifClk = 1'b0;
    always #5 ifClk = ~ifClk;

    // Hard bound on the run time
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge ifClk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            $error("[TB] check %s", tag);
        end
    endtask

    // Full two-cycle request; release and ready apply in the operand-2 cycle
    task automatic applyStimulus(input logic [3:0] cmd, input logic [31:0] d1,
                                 input logic [1:0] tag, input logic [31:0] d2,
                                 input logic relEn, input logic [1:0] relId,
                                 input logic readyEn);
        req_cmd_in  = cmd;
        req_data_in = d1;
        req_tag_in  = tag;
        tick();
        req_cmd_in     = 4'd0;
        req_tag_in     = 2'd0;
        req_data_in    = d2;
        tag_release    = relEn;
        tag_release_id = relId;
        op_ready       = readyEn;
        tick();
        req_data_in    = 32'd0;
        tag_release    = 1'b0;
        tag_release_id = 2'd0;
        op_ready       = 1'b0;
    endtask

    initial begin
        logic [3:0] cmdList [4];
        cmdList[0] = 4'd1;
        cmdList[1] = 4'd2;
        cmdList[2] = 4'd5;
        cmdList[3] = 4'd6;

        ifRst          = 1'b1;
        req_cmd_in     = 4'd0;
        req_data_in    = 32'd0;
        req_tag_in     = 2'd0;
        op_ready       = 1'b0;
        tag_release    = 1'b0;
        tag_release_id = 2'd0;
        tick();
        tick();

        // Reset values
        checkOutput("rst_op_valid",  op_valid,   1'b0);
        checkOutput("rst_count",     fifo_count, 3'd0);
        checkOutput("rst_busy",      busy_tags,  4'h0);
        checkOutput("rst_err_valid", err_valid,  1'b0);
        checkOutput("rst_err_tag",   err_tag,    2'd0);
        checkOutput("rst_err_cause", err_cause,  2'd0);
        checkOutput("rst_op_cmd",    op_cmd,     4'd0);
        checkOutput("rst_op_data1",  op_data1,   32'd0);
        ifRst = 1'b0;
        tick();

        // Single request: cmd=1, d1=5, tag=2, d2=3
        req_cmd_in  = 4'd1;
        req_data_in = 32'h0000_0005;
        req_tag_in  = 2'd2;
        tick();
        checkOutput("single_not_yet_valid", op_valid, 1'b0);
        req_cmd_in  = 4'd0;
        req_tag_in  = 2'd0;
        req_data_in = 32'h0000_0003;
        tick();
        req_data_in = 32'd0;
        checkOutput("single_op_valid", op_valid,   1'b1);
        checkOutput("single_op_cmd",   op_cmd,     4'd1);
        checkOutput("single_op_data1", op_data1,   32'd5);
        checkOutput("single_op_data2", op_data2,   32'd3);
        checkOutput("single_op_tag",   op_tag,     2'd2);
        checkOutput("single_busy",     busy_tags,  4'b0100);
        checkOutput("single_count",    fifo_count, 3'd1);
        checkOutput("single_no_err",   err_valid,  1'b0);
        tick();
        checkOutput("single_hold_valid", op_valid, 1'b1);
        checkOutput("single_hold_data1", op_data1, 32'd5);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        checkOutput("single_pop_count", fifo_count, 3'd0);
        checkOutput("single_pop_valid", op_valid,   1'b0);
        checkOutput("single_busy_kept", busy_tags,  4'b0100);
        tag_release    = 1'b1;
        tag_release_id = 2'd2;
        tick();
        tag_release = 1'b0;
        checkOutput("single_released", busy_tags, 4'b0000);

        // Illegal command
        applyStimulus(4'd3, 32'h11, 2'd1, 32'h22, 1'b0, 2'd0, 1'b0);
        checkOutput("illegal_err_valid", err_valid,  1'b1);
        checkOutput("illegal_err_tag",   err_tag,    2'd1);
        checkOutput("illegal_err_cause", err_cause,  2'b01);
        checkOutput("illegal_count",     fifo_count, 3'd0);
        checkOutput("illegal_busy",      busy_tags,  4'h0);
        tick();
        checkOutput("illegal_pulse_end", err_valid, 1'b0);

        // Tag reuse: tag 0 in flight, then a second tag-0 request
        applyStimulus(4'd1, 32'hA, 2'd0, 32'hB, 1'b0, 2'd0, 1'b0);
        checkOutput("reuse_first_busy",  busy_tags,  4'h1);
        checkOutput("reuse_first_count", fifo_count, 3'd1);
        applyStimulus(4'd2, 32'hC, 2'd0, 32'hD, 1'b0, 2'd0, 1'b0);
        checkOutput("reuse_busy_err",   err_valid,  1'b1);
        checkOutput("reuse_busy_tag",   err_tag,    2'd0);
        checkOutput("reuse_busy_cause", err_cause,  2'b10);
        checkOutput("reuse_busy_count", fifo_count, 3'd1);
        // Same again, with tag 0 released in the completing cycle
        applyStimulus(4'd6, 32'hE, 2'd0, 32'hF, 1'b1, 2'd0, 1'b0);
        checkOutput("reuse_rel_no_err", err_valid,  1'b0);
        checkOutput("reuse_rel_count",  fifo_count, 3'd2);
        checkOutput("reuse_rel_busy",   busy_tags,  4'h1);
        op_ready = 1'b1;
        tick();
        checkOutput("reuse_pop1_count", fifo_count, 3'd1);
        checkOutput("reuse_pop1_cmd",   op_cmd,     4'd6);
        checkOutput("reuse_pop1_data2", op_data2,   32'hF);
        tick();
        op_ready = 1'b0;
        checkOutput("reuse_pop2_count", fifo_count, 3'd0);
        tag_release    = 1'b1;
        tag_release_id = 2'd0;
        tick();
        tag_release = 1'b0;
        checkOutput("reuse_final_busy", busy_tags, 4'h0);

        // Full FIFO: four back-to-back accepts, tags 0..3
        for (int i = 0; i < 4; i++) begin
            applyStimulus(cmdList[i], 32'h10 + 32'(i), 2'(i), 32'h20 + 32'(i),
                          1'b0, 2'd0, 1'b0);
        end
        checkOutput("full_count",    fifo_count, 3'd4);
        checkOutput("full_busy",     busy_tags,  4'hF);
        checkOutput("full_head_cmd", op_cmd,     4'd1);
        checkOutput("full_head_d1",  op_data1,   32'h10);
        // Fifth request (tag 0 freed in its completing cycle) finds the FIFO full
        applyStimulus(4'd5, 32'h99, 2'd0, 32'h98, 1'b1, 2'd0, 1'b0);
        checkOutput("full_err_valid", err_valid,  1'b1);
        checkOutput("full_err_cause", err_cause,  2'b11);
        checkOutput("full_err_tag",   err_tag,    2'd0);
        checkOutput("full_err_count", fifo_count, 3'd4);
        checkOutput("full_err_busy",  busy_tags,  4'hE);
        // Repeat with a pop in the completing cycle
        applyStimulus(4'd6, 32'h77, 2'd0, 32'h76, 1'b0, 2'd0, 1'b1);
        checkOutput("fullpop_no_err", err_valid,  1'b0);
        checkOutput("fullpop_count",  fifo_count, 3'd4);
        checkOutput("fullpop_busy",   busy_tags,  4'hF);
        checkOutput("fullpop_cmd",    op_cmd,     4'd2);
        checkOutput("fullpop_data1",  op_data1,   32'h11);
        checkOutput("fullpop_data2",  op_data2,   32'h21);
        checkOutput("fullpop_tag",    op_tag,     2'd1);

        // Reset while in OPND2
        req_cmd_in  = 4'd5;
        req_data_in = 32'h55;
        req_tag_in  = 2'd3;
        tick();
        ifRst       = 1'b1;
        req_cmd_in  = 4'd0;
        req_tag_in  = 2'd0;
        req_data_in = 32'h66;
        tick();
        ifRst       = 1'b0;
        req_data_in = 32'd0;
        checkOutput("midrst_op_valid",  op_valid,   1'b0);
        checkOutput("midrst_err_valid", err_valid,  1'b0);
        checkOutput("midrst_busy",      busy_tags,  4'h0);
        checkOutput("midrst_count",     fifo_count, 3'd0);
        tick();
        checkOutput("midrst_idle_err",   err_valid,  1'b0);
        checkOutput("midrst_idle_count", fifo_count, 3'd0);
        // Fresh request afterwards
        applyStimulus(4'd2, 32'h100, 2'd3, 32'h40, 1'b0, 2'd0, 1'b0);
        checkOutput("fresh_valid", op_valid,   1'b1);
        checkOutput("fresh_cmd",   op_cmd,     4'd2);
        checkOutput("fresh_data1", op_data1,   32'h100);
        checkOutput("fresh_data2", op_data2,   32'h40);
        checkOutput("fresh_tag",   op_tag,     2'd3);
        checkOutput("fresh_busy",  busy_tags,  4'h8);
        checkOutput("fresh_count", fifo_count, 3'd1);
        checkOutput("fresh_noerr", err_valid,  1'b0);

        // Releasing a tag that is not busy has no effect
        tag_release    = 1'b1;
        tag_release_id = 2'd1;
        tick();
        checkOutput("release_idle_tag", busy_tags, 4'h8);
        tag_release_id = 2'd3;
        tick();
        tag_release = 1'b0;
        checkOutput("release_tag3", busy_tags, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_req_assembler.md
# calc_req_assembler

Per-port request front end for the four-port calculator. It collects the two-cycle request protocol (cycle 1 carries cmd, operand 1 and tag; cycle 2 carries operand 2) into one complete operation. It checks the command and tag, buffers accepted operations in a small FIFO, and hands them to the arithmetic core over a valid/ready handshake. Rejected requests go out as an error pulse to the response stage. One instance sits behind each of req1..req4, directly upstream of the core.

## Interface
- FIFO_DEPTH, 4: operation buffer depth; power of two, ≥2.
- CMD_W, REQ_CMD_WIDTH (4): command width.
- DATA_W, REQ_DATA_WIDTH (32): operand width.
- TAG_W, REQ_TAG_WIDTH (2): tag width; the busy bitmap is 2**TAG_W bits.
- ifClk  in  1  single clock; all state updates on posedge.
- ifRst  in  1  synchronous, active-high reset.
- req_cmd_in  in  CMD_W  request command; 0 = no request.
- req_data_in  in  DATA_W  operand 1 in the command cycle, operand 2 in the following cycle.
- req_tag_in  in  TAG_W  request tag; sampled in the command cycle only.
- op_valid  out  1  FIFO head holds an operation.
- op_ready  in  1  core accepts the head this cycle.
- op_cmd / op_data1 / op_data2 / op_tag  out  CMD_W / DATA_W / DATA_W / TAG_W  FIFO head fields.
- tag_release  in  1  the response stage has issued the final response for tag_release_id.
- tag_release_id  in  TAG_W  tag being freed.
- err_valid  out  1  one-cycle pulse: the request just completed was rejected.
- err_tag  out  TAG_W  tag of the rejected request.
- err_cause  out  2  01 illegal cmd, 10 tag busy, 11 FIFO full.
- busy_tags  out  2**TAG_W  in-flight tag bitmap.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.

## Operation
- FSM states: IDLE, OPND2.
  - IDLE, req_cmd_in≠0: latch cmd, data1 and tag, then go to OPND2. req_cmd_in=0: stay in IDLE.
  - OPND2: latch req_data_in as data2 and go to IDLE unconditionally. req_cmd_in is ignored in this cycle, so it does not start a new request.
- Validation happens on the OPND2 edge, in priority order:
  - illegal cmd (not 1, 2, 5 or 6) → cause 01;
  - tag busy → cause 10;
  - FIFO full → cause 11.
  - A rejected request does not push and does not set a busy bit.
- On accept: push {cmd, data1, data2, tag} and set busy_tags[tag].
- Busy update: busy_next = (busy & ~release_mask) | set_mask. The tag-busy check uses busy & ~release_mask, so a tag released in the completing cycle may be reused immediately. Releasing a tag that is not busy has no effect.
- FIFO: push on accept, pop on op_valid&&op_ready. The full check uses the post-pop occupancy, so push while full with a pop in the same cycle is accepted. Simultaneous push and pop leaves the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Back-to-back requests are allowed: a new cmd may arrive in the cycle right after OPND2, giving a peak rate of one request every 2 cycles.
- Arithmetic is not performed here; operands pass through unmodified.

## Timing
- Reset values: state IDLE; busy_tags 0; fifo_count 0; op_valid 0; op_* 0; err_valid 0; err_tag 0; err_cause 0.
- Command sampled at edge k, operand 2 at edge k+1. err_valid is high for cycle k+1 only, registered.
- With the FIFO empty, op_valid rises after edge k+1. Command to availability is 2 cycles.
- op_* are stable while op_valid && !op_ready.
- The pop takes effect at the edge where op_valid&&op_ready is sampled. The next entry, if any, is presented the following cycle.
- Reset in the middle of a request (state OPND2) drops the partial request. FIFO contents and busy tags are cleared. No error pulse is generated.

## Structure
- Package defs gains:
  - cmd constants CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6;
  - err_cause_t enum (ERR_NONE, ERR_CMD, ERR_TAG, ERR_FULL);
  - asm_state_t {IDLE, OPND2};
  - packed struct calc_op_t {cmd, data1, data2, tag}.
- Sub-module calc_req_fifo: parameterized synchronous FIFO of calc_op_t with push, pop, full, empty and count. The FSM, validation and busy bitmap stay in the top module.

## Test plan
- Single request: cmd=1, data1=0x0000_0005, tag=2, then data2=0x0000_0003 → op_valid after 2 cycles with op_cmd=1, op_data1=5, op_data2=3, op_tag=2; busy_tags=0100.
- Illegal cmd: cmd=3, tag=1 → err_valid pulse with err_tag=1, err_cause=01; fifo_count stays 0; busy_tags stays 0.
- Tag reuse: tag 0 in flight, new request with tag 0 → cause 10. Repeat with tag_release=1, tag_release_id=0 in the completing cycle → accepted.
- Full FIFO: op_ready=0, 5 back-to-back requests with tags 0-3 released between them → first 4 accepted (fifo_count=4), 5th gets cause 11. Repeat with op_ready=1 on the 5th completion cycle → accepted, count stays 4.
- Reset while in OPND2 → next cycle: state IDLE, no op_valid, no err_valid, busy_tags=0. A fresh request afterwards completes normally.
